// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns the EXMEM bundle into a valid/ready
// data-memory transaction, formats returned load data and stalls the
// pipeline until the access has finished.
//
// Handshake: a request transfers on a cycle where req_valid && req_ready;
// req_valid and all req_* fields stay stable until that cycle. A response
// is the single cycle where rsp_valid is high while the request has been
// (or is being) accepted; rsp_valid at any other time is ignored.
module mem_access_unit #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable,
  input  logic                  Mem_REn,
  input  logic                  Mem_WEn,
  input  logic [2:0]            wid,
  input  logic [ADDR_WIDTH-1:0] Mem_Addr,
  input  logic [DATA_WIDTH-1:0] Store_Data,
  input  logic [DATA_WIDTH-1:0] ALU_Result,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic                  req_we,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic [DATA_WIDTH-1:0] req_wdata,
  output logic [7:0]            req_wstrb,
  input  logic                  rsp_valid,
  input  logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [DATA_WIDTH-1:0] WB_Data,
  output logic                  Mem_REn_o,
  output logic                  stall_o,
  output logic                  misalign_o,
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_is_load;
  logic [2:0]            r_wid;
  logic [2:0]            r_off;
  logic [DATA_WIDTH-1:0] r_load_data;

  logic                  w_mem_op;
  logic                  w_misaligned;
  logic                  w_start;
  logic                  w_load_fire;
  logic [7:0]            w_strb_base;
  logic [DATA_WIDTH-1:0] w_raw;
  logic [DATA_WIDTH-1:0] w_fmt;

  assign w_mem_op    = enable & (Mem_REn | Mem_WEn);
  assign w_start     = (r_state == S_IDLE) & w_mem_op & ~w_misaligned;
  assign w_raw       = rsp_rdata >> {r_off, 3'b000};
  assign w_load_fire = r_is_load &
                       (((r_state == S_REQ) & req_ready & rsp_valid) |
                        ((r_state == S_WAIT) & rsp_valid));

  assign req_valid  = (r_state == S_REQ);
  assign Mem_REn_o  = Mem_REn;
  assign stall_o    = w_mem_op & ~w_misaligned & (r_state != S_DONE);
  assign misalign_o = w_mem_op & w_misaligned;
  assign state_o    = r_state;

  // Alignment check and base byte-enable pattern from the access size
  always_comb begin
    w_misaligned = 1'b0;
    w_strb_base  = 8'h01;
    case (wid[1:0])
      2'b00: begin w_misaligned = 1'b0;            w_strb_base = 8'h01; end
      2'b01: begin w_misaligned = Mem_Addr[0];     w_strb_base = 8'h03; end
      2'b10: begin w_misaligned = |Mem_Addr[1:0];  w_strb_base = 8'h0F; end
      default: begin w_misaligned = |Mem_Addr[2:0]; w_strb_base = 8'hFF; end
    endcase
  end

  // Load formatting: pick the lane, then sign- or zero-extend
  always_comb begin
    w_fmt = w_raw;
    case (r_wid)
      3'b000: w_fmt = {{(DATA_WIDTH-8){w_raw[7]}},   w_raw[7:0]};
      3'b001: w_fmt = {{(DATA_WIDTH-16){w_raw[15]}}, w_raw[15:0]};
      3'b010: w_fmt = {{(DATA_WIDTH-32){w_raw[31]}}, w_raw[31:0]};
      3'b100: w_fmt = {{(DATA_WIDTH-8){1'b0}},       w_raw[7:0]};
      3'b101: w_fmt = {{(DATA_WIDTH-16){1'b0}},      w_raw[15:0]};
      3'b110: w_fmt = {{(DATA_WIDTH-32){1'b0}},      w_raw[31:0]};
      default: w_fmt = w_raw;
    endcase
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_next = S_REQ;
      S_REQ:  if (req_ready) w_next = rsp_valid ? S_DONE : S_WAIT;
      S_WAIT: if (rsp_valid) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Request fields latched at start; load data captured on the response
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      req_we      <= 1'b0;
      req_addr    <= '0;
      req_wdata   <= '0;
      req_wstrb   <= 8'h00;
      r_is_load   <= 1'b0;
      r_wid       <= 3'b000;
      r_off       <= 3'b000;
      r_load_data <= '0;
    end else begin
      if (w_start) begin
        req_we    <= Mem_WEn & ~Mem_REn;
        req_addr  <= {Mem_Addr[ADDR_WIDTH-1:3], 3'b000};
        req_wdata <= Store_Data << {Mem_Addr[2:0], 3'b000};
        req_wstrb <= w_strb_base << Mem_Addr[2:0];
        r_is_load <= Mem_REn;
        r_wid     <= wid;
        r_off     <= Mem_Addr[2:0];
      end
      if (w_load_fire) r_load_data <= w_fmt;
    end
  end

  // Writeback mux: finished result in DONE, bypass for non-memory ops
  always_comb begin
    WB_Data = ALU_Result;
    if (r_state == S_DONE)             WB_Data = r_is_load ? r_load_data : ALU_Result;
    else if (w_mem_op & w_misaligned)  WB_Data = '0;
    else if (w_mem_op)                 WB_Data = r_load_data;
    else                               WB_Data = ALU_Result;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with hand-computed expected values.
module tb_mem_access_unit;

  localparam int DW = 64;
  localparam int AW = 64;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          enable = 1'b0;
  logic          Mem_REn = 1'b0;
  logic          Mem_WEn = 1'b0;
  logic [2:0]    wid = 3'b000;
  logic [AW-1:0] Mem_Addr = '0;
  logic [DW-1:0] Store_Data = '0;
  logic [DW-1:0] ALU_Result = '0;
  logic          req_valid;
  logic          req_ready = 1'b0;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [7:0]    req_wstrb;
  logic          rsp_valid = 1'b0;
  logic [DW-1:0] rsp_rdata = '0;
  logic [DW-1:0] WB_Data;
  logic          Mem_REn_o;
  logic          stall_o;
  logic          misalign_o;
  logic [1:0]    state_o;

  int n_checks = 0;
  int n_pass   = 0;

  mem_access_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable(enable), .Mem_REn(Mem_REn),
    .Mem_WEn(Mem_WEn), .wid(wid), .Mem_Addr(Mem_Addr), .Store_Data(Store_Data),
    .ALU_Result(ALU_Result), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .WB_Data(WB_Data), .Mem_REn_o(Mem_REn_o), .stall_o(stall_o),
    .misalign_o(misalign_o), .state_o(state_o)
  );

  // Clock
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
  endtask

  // Advance one cycle and settle past the edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_op(input logic re, input logic we, input logic [2:0] w,
                          input logic [63:0] addr, input logic [63:0] sdata,
                          input logic [63:0] alu);
    enable = 1'b1; Mem_REn = re; Mem_WEn = we; wid = w;
    Mem_Addr = addr; Store_Data = sdata; ALU_Result = alu;
  endtask

  task automatic idle_op();
    enable = 1'b0; Mem_REn = 1'b0; Mem_WEn = 1'b0;
  endtask

  // Load with a same-cycle accept + response: IDLE, REQ, DONE
  task automatic quick_load(input string tag, input logic we, input logic [2:0] w,
                            input logic [63:0] addr, input logic [63:0] rdata,
                            input logic [63:0] exp_addr, input logic [63:0] exp_wb);
    drive_op(1'b1, we, w, addr, 64'h0, 64'hAAAA);
    req_ready = 1'b1; rsp_valid = 1'b1; rsp_rdata = rdata;
    #1;
    check({tag, "_stall_idle"}, {63'd0, stall_o}, 64'd1);
    tick();
    check({tag, "_state_req"}, {62'd0, state_o}, {62'd0, ST_REQ});
    check({tag, "_req_addr"}, req_addr, exp_addr);
    check({tag, "_req_we"}, {63'd0, req_we}, 64'd0);
    tick();
    check({tag, "_state_done"}, {62'd0, state_o}, {62'd0, ST_DONE});
    check({tag, "_stall_done"}, {63'd0, stall_o}, 64'd0);
    check({tag, "_wb"}, WB_Data, exp_wb);
    idle_op(); rsp_valid = 1'b0; req_ready = 1'b0;
    tick();
    check({tag, "_back_idle"}, {62'd0, state_o}, {62'd0, ST_IDLE});
  endtask

  initial begin
    // Reset
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_state", {62'd0, state_o}, {62'd0, ST_IDLE});
    check("rst_req_valid", {63'd0, req_valid}, 64'd0);
    check("rst_req_we", {63'd0, req_we}, 64'd0);
    check("rst_req_wstrb", {56'd0, req_wstrb}, 64'd0);
    check("rst_req_addr", req_addr, 64'd0);
    check("rst_stall", {63'd0, stall_o}, 64'd0);
    check("rst_misalign", {63'd0, misalign_o}, 64'd0);
    rst_i = 1'b1;
    tick();

    // ALU op bypasses memory
    drive_op(1'b0, 1'b0, 3'b011, 64'h0, 64'h0, 64'h1234);
    #1;
    check("alu_wb", WB_Data, 64'h1234);
    check("alu_stall", {63'd0, stall_o}, 64'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("alu_no_req", {63'd0, req_valid}, 64'd0);
    end
    idle_op();

    // Load formatting vectors
    quick_load("lb",  1'b0, 3'b000, 64'h1003, 64'h0000_0000_80FF_0000, 64'h1000, 64'hFFFF_FFFF_FFFF_FF80);
    quick_load("lbu", 1'b0, 3'b100, 64'h1003, 64'h0000_0000_80FF_0000, 64'h1000, 64'h0000_0000_0000_0080);
    quick_load("lh",  1'b0, 3'b001, 64'h1002, 64'h0000_0000_8001_0000, 64'h1000, 64'hFFFF_FFFF_FFFF_8001);
    quick_load("lhu", 1'b0, 3'b101, 64'h1002, 64'h0000_0000_8001_0000, 64'h1000, 64'h0000_0000_0000_8001);
    quick_load("lw",  1'b0, 3'b010, 64'h1004, 64'hF000_0000_0000_0000, 64'h1000, 64'hFFFF_FFFF_F000_0000);
    quick_load("lwu", 1'b0, 3'b110, 64'h1004, 64'hF000_0000_0000_0000, 64'h1000, 64'h0000_0000_F000_0000);
    quick_load("lb7", 1'b0, 3'b000, 64'h2A0F, 64'h7F00_0000_0000_0000, 64'h2A08, 64'h0000_0000_0000_007F);
    // Read and write both set: behaves as a load with req_we=0
    quick_load("rw_both", 1'b1, 3'b011, 64'h1008, 64'h0123_4567_89AB_CDEF, 64'h1008, 64'h0123_4567_89AB_CDEF);

    // SH at 0x2006: write ack one cycle after acceptance
    drive_op(1'b0, 1'b1, 3'b001, 64'h2006, 64'hABCD, 64'h55);
    req_ready = 1'b1; rsp_valid = 1'b0;
    #1;
    check("sh_stall_idle", {63'd0, stall_o}, 64'd1);
    tick();
    check("sh_req_valid", {63'd0, req_valid}, 64'd1);
    check("sh_req_we", {63'd0, req_we}, 64'd1);
    check("sh_req_addr", req_addr, 64'h2000);
    check("sh_req_wstrb", {56'd0, req_wstrb}, 64'hC0);
    check("sh_req_wdata", req_wdata, 64'hABCD_0000_0000_0000);
    tick();
    req_ready = 1'b0;
    check("sh_state_wait", {62'd0, state_o}, {62'd0, ST_WAIT});
    check("sh_stall_wait", {63'd0, stall_o}, 64'd1);
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    check("sh_state_done", {62'd0, state_o}, {62'd0, ST_DONE});
    check("sh_stall_done", {63'd0, stall_o}, 64'd0);
    check("sh_wb_alu", WB_Data, 64'h55);
    idle_op();
    tick();

    // LD at 0x3000 with back-pressure and a delayed response
    drive_op(1'b1, 1'b0, 3'b011, 64'h3000, 64'h0, 64'h99);
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = 64'h0123_4567_89AB_CDEF;
    #1;
    check("ld_stall_idle", {63'd0, stall_o}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ld_hold_valid", {63'd0, req_valid}, 64'd1);
      check("ld_hold_addr", req_addr, 64'h3000);
      check("ld_hold_wstrb", {56'd0, req_wstrb}, 64'hFF);
      check("ld_hold_we", {63'd0, req_we}, 64'd0);
      check("ld_hold_stall", {63'd0, stall_o}, 64'd1);
    end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    check("ld_wait1_state", {62'd0, state_o}, {62'd0, ST_WAIT});
    check("ld_wait1_stall", {63'd0, stall_o}, 64'd1);
    tick();
    check("ld_wait2_stall", {63'd0, stall_o}, 64'd1);
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    check("ld_state_done", {62'd0, state_o}, {62'd0, ST_DONE});
    check("ld_stall_done", {63'd0, stall_o}, 64'd0);
    check("ld_wb", WB_Data, 64'h0123_4567_89AB_CDEF);
    idle_op();
    tick();

    // Misaligned LW at 0x4002
    drive_op(1'b1, 1'b0, 3'b010, 64'h4002, 64'h0, 64'h77);
    req_ready = 1'b1; rsp_valid = 1'b0;
    #1;
    check("mis_flag", {63'd0, misalign_o}, 64'd1);
    check("mis_stall", {63'd0, stall_o}, 64'd0);
    check("mis_wb", WB_Data, 64'd0);
    tick();
    check("mis_state", {62'd0, state_o}, {62'd0, ST_IDLE});
    check("mis_no_req", {63'd0, req_valid}, 64'd0);
    idle_op(); req_ready = 1'b0;
    tick();

    // Reset while waiting, then a late response
    drive_op(1'b1, 1'b0, 3'b010, 64'h5000, 64'h0, 64'h11);
    req_ready = 1'b1; rsp_valid = 1'b0;
    tick();
    tick();
    req_ready = 1'b0;
    check("rstw_state_wait", {62'd0, state_o}, {62'd0, ST_WAIT});
    rst_i = 1'b0;
    #1;
    check("rstw_state_idle", {62'd0, state_o}, {62'd0, ST_IDLE});
    check("rstw_req_valid", {63'd0, req_valid}, 64'd0);
    check("rstw_req_addr", req_addr, 64'd0);
    idle_op();
    tick();
    rst_i = 1'b1;
    rsp_valid = 1'b1; rsp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    rsp_valid = 1'b0;
    check("late_rsp_state", {62'd0, state_o}, {62'd0, ST_IDLE});
    drive_op(1'b1, 1'b0, 3'b011, 64'h6000, 64'h0, 64'h22);
    #1;
    check("late_rsp_wb", WB_Data, 64'd0);
    check("late_rsp_stall", {63'd0, stall_o}, 64'd1);
    idle_op();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety net against a stuck run
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
